spi_regbank_burst: RTL and testbench

SPI mode-0 slave with an integrated, parametrised register bank. It generalises the fixed 16-bit-frame, 128x8 register file to configurable address width, data width and depth. It adds multi-word burst transfers with address auto-increment and wrap, a read-only status window fed from fabric, and a write-notify strobe. It sits at the chip pin boundary; the control/status registers for the datapath hang off it.

---
 rtl/spi_regbank_burst.sv | 164 ++++++++++++++++
 tb/tb_spi_regbank_burst.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_regbank_burst.sv
// SPI mode-0 slave with a parametrised register bank: burst read/write with address
// auto-increment, read-only status window and write-notify strobe. Optional macro: SPI_REGBANK_LOCK_EN.
module spi_regbank_burst #(
    parameter int ADDR_BITS = 7,
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 128,
    parameter int RO_BASE   = 120,
    parameter logic [DATA_BITS-1:0] RESET_VAL = '0,
    localparam int RO_W     = (DEPTH > RO_BASE) ? (DEPTH - RO_BASE) : 1
) (
    input  logic                           sclk,
    input  logic                           rst_n,
    input  logic                           ss_n,
    input  logic                           mosi,
    output logic                           miso,
    output logic                           miso_oe,
    input  logic [RO_W*DATA_BITS-1:0]      ro_in,
    output logic [RO_BASE*DATA_BITS-1:0]   regs_out,
    output logic                           wr_strobe,
    output logic [ADDR_BITS-1:0]           wr_addr,
    output logic                           busy
);

    localparam int HDR_BITS = 1 + ADDR_BITS;
    localparam int SR_BITS  = (HDR_BITS > DATA_BITS) ? HDR_BITS : DATA_BITS;
    localparam int CNT_BITS = (SR_BITS > 1) ? $clog2(SR_BITS) : 1;

    localparam logic [0:0] PH_HDR  = 1'b0;
    localparam logic [0:0] PH_DATA = 1'b1;

    logic [0:0]           phase_q, phase_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;
    logic [SR_BITS-1:0]   rx_q, rx_d;
    logic [DATA_BITS-1:0] tx_q, tx_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 rw_q, rw_d;

    logic [DATA_BITS-1:0] regs_q [RO_BASE];
    logic                 wr_strobe_q;
    logic [ADDR_BITS-1:0] wr_addr_q;
    logic                 miso_q;

    logic                 frame_rst_n;
    logic [HDR_BITS-1:0]  hdr;
    logic [DATA_BITS-1:0] word;
    logic                 hdr_done, word_done;
    logic [ADDR_BITS-1:0] addr_nxt, rd_addr;
    logic [DATA_BITS-1:0] rd_data;
    logic                 locked, wr_en;

    // Frame state is held clear whenever the slave is deselected.
    assign frame_rst_n = rst_n & ~ss_n;

    assign hdr       = {rx_q[HDR_BITS-2:0], mosi};
    assign word      = {rx_q[DATA_BITS-2:0], mosi};
    assign hdr_done  = (cnt_q == CNT_BITS'(HDR_BITS - 1));
    assign word_done = (cnt_q == CNT_BITS'(DATA_BITS - 1));
    assign addr_nxt  = (addr_q == ADDR_BITS'(DEPTH - 1)) ? '0 : addr_q + 1'b1;

`ifdef SPI_REGBANK_LOCK_EN
    assign locked = regs_q[RO_BASE-1][0] && (32'(addr_q) < RO_BASE - 1);
`else
    assign locked = 1'b0;
`endif

    assign wr_en = (phase_q == PH_DATA) && word_done && !rw_q &&
                   (32'(addr_q) < RO_BASE) && !locked;

    // Single read port: the header address at header end, otherwise the prefetch address.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        rd_addr = (phase_q == PH_HDR) ? hdr[ADDR_BITS-1:0] : addr_nxt;
        rd_data = '0;
        for (int i = 0; i < RO_BASE; i++)
            if (32'(rd_addr) == i) rd_data = regs_q[i];
        for (int k = 0; k < RO_W; k++)
            if ((RO_BASE + k < DEPTH) && (32'(rd_addr) == RO_BASE + k))
                rd_data = ro_in[k*DATA_BITS +: DATA_BITS];
    end

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q + 1'b1;
        rx_d    = {rx_q[SR_BITS-2:0], mosi};
        tx_d    = tx_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        if (phase_q == PH_HDR) begin
            if (hdr_done) begin
                phase_d = PH_DATA;
                cnt_d   = '0;
                rw_d    = hdr[HDR_BITS-1];
                addr_d  = hdr[ADDR_BITS-1:0];
                tx_d    = rd_data;
            end
        end else begin
            tx_d = tx_q << 1;
            if (word_done) begin
                cnt_d  = '0;
                addr_d = addr_nxt;
                tx_d   = rd_data;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sclk or negedge frame_rst_n) begin
        if (!frame_rst_n) begin
            phase_q <= PH_HDR;
            cnt_q   <= '0;
            rx_q    <= '0;
            tx_q    <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
        end
    end

    // NOTE: the bank is built from flops and must come out of reset at RESET_VAL, so it is reset.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RO_BASE; i++) regs_q[i] <= RESET_VAL;
`ifdef SPI_REGBANK_LOCK_EN
            regs_q[RO_BASE-1][0] <= 1'b0;
`endif
        end else begin
            for (int i = 0; i < RO_BASE; i++)
                if (wr_en && (32'(addr_q) == i)) regs_q[i] <= word;
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            wr_strobe_q <= wr_en;
            if (wr_en) wr_addr_q <= addr_q;
        end
    end

    // Launch on the falling edge so the master samples a settled bit on the next rising edge.
    always_ff @(negedge sclk or negedge frame_rst_n) begin
        if (!frame_rst_n) miso_q <= 1'b0;
        else              miso_q <= (phase_q == PH_DATA) ? tx_q[DATA_BITS-1] : 1'b0;
    end

    for (genvar g = 0; g < RO_BASE; g++) begin : g_regs_out
        assign regs_out[g*DATA_BITS +: DATA_BITS] = regs_q[g];
    end

    assign miso      = miso_q;
    assign miso_oe   = ~ss_n;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign busy      = (phase_q == PH_DATA);

endmodule

// File: tb/tb_spi_regbank_burst.sv
// Self-checking bench for spi_regbank_burst (default parameters); lock tests run when
// SPI_REGBANK_LOCK_EN is defined. Expected reads/strobes are queued at drive time.
module tb_spi_regbank_burst;

    logic         sclk, rst_n, ss_n, mosi;
    logic         miso, miso_oe, wr_strobe, busy;
    logic [63:0]  ro_in;
    logic [959:0] regs_out;
    logic [6:0]   wr_addr;

    spi_regbank_burst dut (
        .sclk(sclk), .rst_n(rst_n), .ss_n(ss_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .ro_in(ro_in), .regs_out(regs_out),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .busy(busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] model_regs [120];
    logic [7:0] wdata_q [$];
    logic [7:0] exp_rd [$];
    logic [6:0] exp_wa [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] model_rd(input int a);
        if (a < 120)      return model_regs[a];
        else if (a < 128) return ro_in[(a-120)*8 +: 8];
        else              return 8'h00;
    endfunction

    function automatic bit model_writable(input int a);
        if (a >= 120) return 1'b0;
`ifdef SPI_REGBANK_LOCK_EN
        if (model_regs[119][0] && a < 119) return 1'b0;
`endif
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 120; i++) model_regs[i] = 8'h00;
    endtask

    task automatic check_regs(input string tag);
        int bad = 0;
        for (int i = 0; i < 120; i++)
            if (regs_out[i*8 +: 8] !== model_regs[i]) bad++;
        check(tag, bad, 0);
    endtask

    // Drive one bit: set mosi while sclk is low, sample miso just before the rising edge.
    task automatic rise_bit(input logic b, output logic m);
        mosi = b;
        #4;
        m = miso;
        sclk = 1'b1;
        #1;
    endtask

    task automatic fall();
        #4;
        sclk = 1'b0;
    endtask

    task automatic spi_frame(input logic rw, input logic [6:0] addr, input int nbits, input bit rst_cut);
        logic [7:0] hdr, word, rword, e;
        logic       m, hdr_miso, exp_strobe;
        int         a;
        hdr = {rw, addr};
        a = addr;
        hdr_miso = 1'b0;
        word = 8'h00;
        rword = 8'h00;
        exp_strobe = 1'b0;
        ss_n = 1'b0;
        #5;
        check("miso_oe_on", miso_oe, 1);
        for (int i = 7; i >= 0; i--) begin
            rise_bit(hdr[i], m);
            hdr_miso |= m;
            fall();
        end
        check("hdr_miso", hdr_miso, 0);
        check("busy_on", busy, 1);
        for (int b = 0; b < nbits; b++) begin
            if (b % 8 == 0) begin
                word = rw ? 8'h00 : wdata_q.pop_front();
                exp_strobe = 1'b0;
                if (b + 8 <= nbits) begin
                    if (rw) exp_rd.push_back(model_rd(a));
                    else if (model_writable(a)) begin
                        exp_wa.push_back(7'(a));
                        exp_strobe = 1'b1;
                        model_regs[a] = word;
                    end
                    a = (a == 127) ? 0 : a + 1;
                end
            end
            rise_bit(word[7 - (b % 8)], m);
            rword = {rword[6:0], m};
            if (b % 8 == 7) begin
                if (rw) begin
                    e = exp_rd.pop_front();
                    check("rd_data", rword, e);
                end else begin
                    check("wr_strobe", wr_strobe, exp_strobe);
                    if (exp_strobe) check("wr_addr", wr_addr, exp_wa.pop_front());
                end
            end
            fall();
        end
        if (rst_cut) begin
            rst_n = 1'b0;
            model_reset();
            #2;
        end
        ss_n = 1'b1;
        #5;
        check("busy_off", busy, 0);
        check("miso_idle", miso, 0);
        check("miso_oe_off", miso_oe, 0);
        sclk = 1'b1;
        #1;
        check("strobe_clear", wr_strobe, 0);
        #4;
        sclk = 1'b0;
        #5;
        if (rst_cut) begin
            check("wr_addr_rst", wr_addr, 0);
            rst_n = 1'b1;
            #5;
        end
    endtask

    initial begin
        logic [6:0] base;
        sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0; rst_n = 1'b0;
        ro_in = 64'h5CB6_B5B4_B3B2_B1B0;
        model_reset();
        #20;
        check("rst_miso", miso, 0);
        check("rst_strobe", wr_strobe, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_busy", busy, 0);
        check_regs("rst_regs");
        rst_n = 1'b1;
        #10;

        // Single write then read of address 5.
        wdata_q.push_back(8'hA5);
        spi_frame(1'b0, 7'd5, 8, 1'b0);
        check("reg5", regs_out[5*8 +: 8], 64'hA5);
        spi_frame(1'b1, 7'd5, 8, 1'b0);

        // Burst write and read back at 0x10.
        wdata_q.push_back(8'h11); wdata_q.push_back(8'h22); wdata_q.push_back(8'h33);
        spi_frame(1'b0, 7'h10, 24, 1'b0);
        check_regs("burst_regs");
        spi_frame(1'b1, 7'h10, 24, 1'b0);

        // RO window and wrap from 127 to 0; write into RO ignored.
        spi_frame(1'b1, 7'd127, 16, 1'b0);
        wdata_q.push_back(8'hFF);
        spi_frame(1'b0, 7'd121, 8, 1'b0);
        spi_frame(1'b1, 7'd121, 8, 1'b0);

        // Partial data word is dropped; a full word then lands.
        wdata_q.push_back(8'hE7);
        spi_frame(1'b0, 7'd3, 4, 1'b0);
        check("reg3_partial", regs_out[3*8 +: 8], 64'h00);
        wdata_q.push_back(8'h3C);
        spi_frame(1'b0, 7'd3, 8, 1'b0);
        check("reg3", regs_out[3*8 +: 8], 64'h3C);

        // Wrapping burst write across RO window into 0,1, then read back.
        for (int i = 0; i < 4; i++) wdata_q.push_back(8'(8'h60 + i));
        spi_frame(1'b0, 7'd126, 32, 1'b0);
        spi_frame(1'b1, 7'd126, 32, 1'b0);
        check_regs("wrap_regs");

        // Random bursts.
        for (int r = 0; r < 3; r++) begin
            base = 7'($urandom_range(0, 110));
            for (int i = 0; i < 4; i++) wdata_q.push_back(8'($urandom));
            spi_frame(1'b0, base, 32, 1'b0);
            spi_frame(1'b1, base, 32, 1'b0);
        end
        check_regs("rand_regs");

`ifdef SPI_REGBANK_LOCK_EN
        wdata_q.push_back(8'h01);
        spi_frame(1'b0, 7'd119, 8, 1'b0);
        wdata_q.push_back(8'h77);
        spi_frame(1'b0, 7'd2, 8, 1'b0);
        check("reg2_locked", regs_out[2*8 +: 8], 64'h00);
        wdata_q.push_back(8'h00);
        spi_frame(1'b0, 7'd119, 8, 1'b0);
        wdata_q.push_back(8'h77);
        spi_frame(1'b0, 7'd2, 8, 1'b0);
        check("reg2_unlocked", regs_out[2*8 +: 8], 64'h77);
        wdata_q.push_back(8'h01);
        spi_frame(1'b0, 7'd119, 8, 1'b0);
`endif

        // Reset mid-burst: one word committed, then the frame is aborted by rst_n.
        wdata_q.push_back(8'h99); wdata_q.push_back(8'h42);
        spi_frame(1'b0, 7'h10, 11, 1'b1);
        check_regs("midrst_regs");
        check("lock_bit_clear", regs_out[119*8], 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
